// File: rtl/myfilter_pkg.sv
// Shared types and constants for the multi-channel filter unit and its configuration chain.
package myfilter_pkg;

    localparam int DATABITS  = 16;
    localparam int COEFFBITS = 16;
    localparam int SHIFTBITS = 6;
    localparam int CFGBITS   = 8;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SCALE
    } state_t;

    typedef struct packed {
        logic [SHIFTBITS-1:0] shift;
        logic                 sat;
        logic                 bypass;
    } cfg_t;

    function automatic int chain_len(input int taps, input int coeffbits);
        return taps * coeffbits + CFGBITS;
    endfunction

endpackage

// File: rtl/filter_unit_mc_if.sv
// Sample-side bus of the filter unit: input samples, filtered output and status flags.
interface filter_unit_mc_if #(
    parameter int DATABITS = myfilter_pkg::DATABITS,
    parameter int CHW      = 1
);
    logic [DATABITS-1:0] ext_in;
    logic                extready_in;
    logic [DATABITS-1:0] ext_out;
    logic                extvalid_out;
    logic [CHW-1:0]      extch_out;
    logic                extbusy_out;
    logic                ovf_out;

    modport master (
        output ext_in, extready_in,
        input  ext_out, extvalid_out, extch_out, extbusy_out, ovf_out
    );

    modport slave (
        input  ext_in, extready_in,
        output ext_out, extvalid_out, extch_out, extbusy_out, ovf_out
    );
endinterface

// File: rtl/filter_cfg_chain.sv
// Serial scan chain with shadow/active registers holding coefficients and mode bits.
module filter_cfg_chain #(
    parameter int TAPS      = 4,
    parameter int COEFFBITS = myfilter_pkg::COEFFBITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sde_in,
    input  logic                      sd_in,
    input  logic                      ul_in,
    input  logic                      dl_in,
    output logic                      sd_out,
    output logic [TAPS*COEFFBITS-1:0] coeff_flat,
    output myfilter_pkg::cfg_t        cfg
);
    import myfilter_pkg::*;

    localparam int L = chain_len(TAPS, COEFFBITS);

    logic [L-1:0] shadow;
    logic [L-1:0] active;

    // Readback load wins over shifting; commit and readback in one cycle swap the registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (dl_in) begin
                shadow <= active;
            end else if (sde_in) begin
                shadow <= {shadow[L-2:0], sd_in};
            end
            if (ul_in) begin
                active <= shadow;
            end
        end
    end

    assign sd_out     = shadow[L-1];
    assign coeff_flat = active[L-1:CFGBITS];
    assign cfg        = active[CFGBITS-1:0];

endmodule

// File: rtl/filter_unit_mc.sv
// Time-multiplexed signed FIR with one shared multiplier and per-channel delay lines.
module filter_unit_mc #(
    parameter int DATABITS  = myfilter_pkg::DATABITS,
    parameter int COEFFBITS = myfilter_pkg::COEFFBITS,
    parameter int TAPS      = 4,
    parameter int CHANNELS  = 2,
    parameter int ACCBITS   = DATABITS + COEFFBITS + $clog2(TAPS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sde_in,
    input  logic            sd_in,
    input  logic            ul_in,
    input  logic            dl_in,
    output logic            sd_out,
    filter_unit_mc_if.slave ext
);
    import myfilter_pkg::*;

    localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TAPW     = $clog2(TAPS);
    localparam int PRODBITS = DATABITS + COEFFBITS;

    logic [TAPS*COEFFBITS-1:0]  coeff_flat;
    cfg_t                       cfg;
    state_t                     state;
    state_t                     next_state;
    logic [TAPW-1:0]            tap_idx;
    logic [CHW-1:0]             ch_cnt;
    logic [CHW-1:0]             busy_ch;
    logic signed [DATABITS-1:0] dline [CHANNELS][TAPS];
    logic signed [ACCBITS-1:0]  acc;
    logic signed [DATABITS-1:0] mac_x;
    logic signed [COEFFBITS-1:0] mac_c;
    logic signed [PRODBITS-1:0] prod;
    logic signed [ACCBITS-1:0]  shifted;
    logic [DATABITS-1:0]        result;
    logic                       accept;
    logic                       drop;

    filter_cfg_chain #(
        .TAPS      (TAPS),
        .COEFFBITS (COEFFBITS)
    ) u_cfg (
        .clk        (clk),
        .rst        (rst),
        .sde_in     (sde_in),
        .sd_in      (sd_in),
        .ul_in      (ul_in),
        .dl_in      (dl_in),
        .sd_out     (sd_out),
        .coeff_flat (coeff_flat),
        .cfg        (cfg)
    );

    assign ext.extbusy_out = (state != IDLE);
    assign accept          = ext.extready_in && (state == IDLE);
    assign drop            = ext.extready_in && (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A commit while computing abandons the sample in flight.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && !cfg.bypass) next_state = MAC;
            MAC:     if (tap_idx == TAPW'(TAPS - 1)) next_state = SCALE;
            SCALE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (ul_in && (state != IDLE)) begin
            next_state = IDLE;
        end
    end

    always_comb begin
        mac_x = dline[busy_ch][tap_idx];
        mac_c = coeff_flat[(TAPS - 1 - int'(tap_idx)) * COEFFBITS +: COEFFBITS];
        prod  = mac_x * mac_c;
        if (int'(cfg.shift) >= ACCBITS) begin
            shifted = {ACCBITS{acc[ACCBITS-1]}};
        end else begin
            shifted = acc >>> cfg.shift;
        end
        result = shifted[DATABITS-1:0];
        // Out of range when the bits above the output sign bit disagree with it.
        if (cfg.sat && (shifted[ACCBITS-1:DATABITS-1] != {(ACCBITS-DATABITS+1){shifted[ACCBITS-1]}})) begin
            result = shifted[ACCBITS-1] ? {1'b1, {(DATABITS-1){1'b0}}}
                                        : {1'b0, {(DATABITS-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int t = 0; t < TAPS; t++) begin
                    dline[c][t] <= '0;
                end
            end
            acc              <= '0;
            tap_idx          <= '0;
            ch_cnt           <= '0;
            busy_ch          <= '0;
            ext.ext_out      <= '0;
            ext.extvalid_out <= 1'b0;
            ext.extch_out    <= '0;
            ext.ovf_out      <= 1'b0;
        end else begin
            ext.extvalid_out <= 1'b0;
            if (accept) begin
                dline[ch_cnt][0] <= ext.ext_in;
                for (int t = 1; t < TAPS; t++) begin
                    dline[ch_cnt][t] <= dline[ch_cnt][t-1];
                end
                ch_cnt  <= (ch_cnt == CHW'(CHANNELS - 1)) ? '0 : ch_cnt + 1'b1;
                busy_ch <= ch_cnt;
                acc     <= '0;
                tap_idx <= '0;
                if (cfg.bypass) begin
                    ext.ext_out      <= ext.ext_in;
                    ext.extvalid_out <= 1'b1;
                    ext.extch_out    <= ch_cnt;
                end
            end
            if (state == MAC) begin
                acc     <= acc + $signed({{(ACCBITS-PRODBITS){prod[PRODBITS-1]}}, prod});
                tap_idx <= tap_idx + 1'b1;
            end
            if ((state == SCALE) && !ul_in) begin
                ext.ext_out      <= result;
                ext.extvalid_out <= 1'b1;
                ext.extch_out    <= busy_ch;
            end
            // A drop in the same cycle as a commit is still recorded.
            if (ul_in) begin
                ext.ovf_out <= 1'b0;
            end
            if (drop) begin
                ext.ovf_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_filter_unit_mc.sv
// Directed self-checking bench for filter_unit_mc (TAPS=4, CHANNELS=2, 16-bit data).
module tb_filter_unit_mc;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sde_in = 1'b0;
    logic sd_in = 1'b0;
    logic ul_in = 1'b0;
    logic dl_in = 1'b0;
    logic sd_out;
    int   checks = 0;
    int   failures = 0;

    filter_unit_mc_if #(.DATABITS(16), .CHW(1)) ifc ();

    filter_unit_mc #(
        .DATABITS  (16),
        .COEFFBITS (16),
        .TAPS      (4),
        .CHANNELS  (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sde_in (sde_in),
        .sd_in  (sd_in),
        .ul_in  (ul_in),
        .dl_in  (dl_in),
        .sd_out (sd_out),
        .ext    (ifc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] cfg_word(input logic [15:0] c0, input logic [15:0] c1,
                                             input logic [15:0] c2, input logic [15:0] c3,
                                             input logic [5:0] sh, input logic sat, input logic byp);
        return {c0, c1, c2, c3, sh, sat, byp};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic shift_word(input logic [71:0] word);
        for (int i = 71; i >= 0; i--) begin
            sde_in = 1'b1;
            sd_in  = word[i];
            tick();
        end
        sde_in = 1'b0;
        sd_in  = 1'b0;
    endtask

    task automatic pulse_ul();
        ul_in = 1'b1;
        tick();
        ul_in = 1'b0;
    endtask

    task automatic load_cfg(input logic [71:0] word);
        shift_word(word);
        pulse_ul();
    endtask

    // Present one FIR sample and expect its result exactly six cycles later.
    task automatic applyStimulus(input logic [15:0] sample, input logic [15:0] exp_out,
                                 input logic exp_ch, input string tag);
        int lat;
        bit seen;
        ifc.ext_in      = sample;
        ifc.extready_in = 1'b1;
        tick();
        ifc.extready_in = 1'b0;
        checkOutput({tag, "_busy"}, 72'(ifc.extbusy_out), 72'(1));
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            if (ifc.extvalid_out) begin
                seen = 1'b1;
            end else begin
                tick();
                lat++;
            end
        end
        checkOutput({tag, "_lat"}, 72'(lat), 72'(6));
        checkOutput({tag, "_out"}, 72'(ifc.ext_out), 72'(exp_out));
        checkOutput({tag, "_ch"}, 72'(ifc.extch_out), 72'(exp_ch));
        tick();
        checkOutput({tag, "_pulse"}, 72'(ifc.extvalid_out), 72'(0));
    endtask

    initial begin
        logic [71:0] pat;
        logic [71:0] cap;
        int          vcount;

        ifc.ext_in      = '0;
        ifc.extready_in = 1'b0;

        do_reset();
        checkOutput("rst_out",   72'(ifc.ext_out),      72'(0));
        checkOutput("rst_valid", 72'(ifc.extvalid_out), 72'(0));
        checkOutput("rst_busy",  72'(ifc.extbusy_out),  72'(0));
        checkOutput("rst_ovf",   72'(ifc.ovf_out),      72'(0));
        checkOutput("rst_sd",    72'(sd_out),           72'(0));

        load_cfg(cfg_word(16'd1, 16'd0, 16'd0, 16'd0, 6'd0, 1'b0, 1'b0));
        applyStimulus(16'd100, 16'd100, 1'b0, "single");
        checkOutput("single_hold", 72'(ifc.ext_out), 72'(100));

        do_reset();
        load_cfg(cfg_word(16'd1, 16'd2, 16'd3, 16'd4, 6'd0, 1'b0, 1'b0));
        applyStimulus(16'd1, 16'd1,  1'b0, "il0");
        applyStimulus(16'd5, 16'd5,  1'b1, "il1");
        applyStimulus(16'd0, 16'd2,  1'b0, "il2");
        applyStimulus(16'd0, 16'd10, 1'b1, "il3");
        applyStimulus(16'd0, 16'd3,  1'b0, "il4");
        applyStimulus(16'd0, 16'd15, 1'b1, "il5");
        applyStimulus(16'd0, 16'd4,  1'b0, "il6");

        do_reset();
        load_cfg(cfg_word(16'h7FFF, 16'h7FFF, 16'd0, 16'd0, 6'd15, 1'b1, 1'b0));
        applyStimulus(16'h7FFF, 16'h7FFE, 1'b0, "sat1_a");
        applyStimulus(16'h0000, 16'h0000, 1'b1, "sat1_b");
        applyStimulus(16'h7FFF, 16'h7FFF, 1'b0, "sat1_c");

        do_reset();
        load_cfg(cfg_word(16'h7FFF, 16'h7FFF, 16'd0, 16'd0, 6'd15, 1'b0, 1'b0));
        applyStimulus(16'h7FFF, 16'h7FFE, 1'b0, "wrap_a");
        applyStimulus(16'h0000, 16'h0000, 1'b1, "wrap_b");
        applyStimulus(16'h7FFF, 16'hFFFC, 1'b0, "wrap_c");

        do_reset();
        pat = cfg_word(16'h0003, 16'h5A5A, 16'h8001, 16'h7FFE, 6'd1, 1'b1, 1'b0);
        load_cfg(pat);
        applyStimulus(16'd10, 16'd15, 1'b0, "rb_pre");
        shift_word(72'd0);
        dl_in = 1'b1;
        tick();
        dl_in = 1'b0;
        cap = '0;
        for (int i = 71; i >= 0; i--) begin
            cap[i] = sd_out;
            sde_in = 1'b1;
            tick();
        end
        sde_in = 1'b0;
        checkOutput("rb_chain", cap, pat);
        applyStimulus(16'd20, 16'd30, 1'b1, "rb_post");

        do_reset();
        load_cfg(cfg_word(16'd1, 16'd1, 16'd0, 16'd0, 6'd0, 1'b0, 1'b0));
        ifc.ext_in      = 16'd100;
        ifc.extready_in = 1'b1;
        tick();
        ifc.extready_in = 1'b0;
        tick();
        ifc.ext_in      = 16'd55;
        ifc.extready_in = 1'b1;
        checkOutput("drop_busy", 72'(ifc.extbusy_out), 72'(1));
        tick();
        ifc.extready_in = 1'b0;
        checkOutput("drop_ovf", 72'(ifc.ovf_out), 72'(1));
        tick();
        tick();
        tick();
        checkOutput("drop_valid", 72'(ifc.extvalid_out), 72'(1));
        checkOutput("drop_out",   72'(ifc.ext_out),      72'(100));
        checkOutput("drop_ch",    72'(ifc.extch_out),    72'(0));
        tick();
        applyStimulus(16'd7, 16'd7, 1'b1, "drop_next");
        checkOutput("drop_sticky", 72'(ifc.ovf_out), 72'(1));
        pulse_ul();
        checkOutput("drop_clear", 72'(ifc.ovf_out), 72'(0));

        do_reset();
        load_cfg(cfg_word(16'd1, 16'd1, 16'd0, 16'd0, 6'd0, 1'b0, 1'b0));
        ifc.ext_in      = 16'd9;
        ifc.extready_in = 1'b1;
        tick();
        ifc.extready_in = 1'b0;
        tick();
        tick();
        ul_in = 1'b1;
        tick();
        ul_in = 1'b0;
        checkOutput("abort_busy", 72'(ifc.extbusy_out), 72'(0));
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            if (ifc.extvalid_out) vcount++;
            tick();
        end
        checkOutput("abort_novalid", 72'(vcount), 72'(0));
        applyStimulus(16'd11, 16'd11, 1'b1, "abort_ch1");
        applyStimulus(16'd2,  16'd11, 1'b0, "abort_keep");

        ifc.ext_in      = 16'd9;
        ifc.extready_in = 1'b1;
        tick();
        ifc.extready_in = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mrst_out",   72'(ifc.ext_out),      72'(0));
        checkOutput("mrst_valid", 72'(ifc.extvalid_out), 72'(0));
        checkOutput("mrst_ch",    72'(ifc.extch_out),    72'(0));
        checkOutput("mrst_busy",  72'(ifc.extbusy_out),  72'(0));
        checkOutput("mrst_ovf",   72'(ifc.ovf_out),      72'(0));
        applyStimulus(16'd5, 16'd0, 1'b0, "mrst_next");

        do_reset();
        load_cfg(cfg_word(16'd3, 16'd3, 16'd3, 16'd3, 6'd0, 1'b0, 1'b1));
        ifc.ext_in      = 16'hFFF9;
        ifc.extready_in = 1'b1;
        checkOutput("byp_busy0", 72'(ifc.extbusy_out), 72'(0));
        tick();
        ifc.ext_in = 16'd42;
        checkOutput("byp_out0",   72'(ifc.ext_out),      72'(16'hFFF9));
        checkOutput("byp_valid0", 72'(ifc.extvalid_out), 72'(1));
        checkOutput("byp_ch0",    72'(ifc.extch_out),    72'(0));
        checkOutput("byp_busy1",  72'(ifc.extbusy_out),  72'(0));
        tick();
        ifc.extready_in = 1'b0;
        checkOutput("byp_out1",   72'(ifc.ext_out),      72'(42));
        checkOutput("byp_valid1", 72'(ifc.extvalid_out), 72'(1));
        checkOutput("byp_ch1",    72'(ifc.extch_out),    72'(1));
        checkOutput("byp_busy2",  72'(ifc.extbusy_out),  72'(0));
        tick();
        checkOutput("byp_valid2", 72'(ifc.extvalid_out), 72'(0));
        checkOutput("byp_hold",   72'(ifc.ext_out),      72'(42));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
